// File: rtl/recv_sched_pkg.sv
// Shared types and defaults for the receive-queue scheduler.
package recv_sched_pkg;

  localparam int unsigned DEF_NUM_Q     = 16;
  localparam int unsigned DEF_DEPTH     = 64;
  localparam int unsigned DEF_BURST_MAX = 8;
  localparam int unsigned DEF_AF_MARGIN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    READ = 2'd2
  } schedState_t;

  function automatic int unsigned addrWidth(input int unsigned numQ, input int unsigned depth);
    return $clog2(numQ) + $clog2(depth);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rrPtr wins.
module rr_arbiter #(
  parameter int unsigned NUM_Q = 16,
  parameter int unsigned QN_W  = $clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] request,
  input  logic [QN_W-1:0]  rrPtr,
  output logic [NUM_Q-1:0] grant,
  output logic [QN_W-1:0]  grantQN
);

  logic             found;
  logic [QN_W-1:0]  idx;

  // NUM_Q is a power of two, so the rotated index wraps naturally in QN_W bits.
  always_comb begin
    grant   = '0;
    grantQN = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      idx = rrPtr + QN_W'(i);
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grantQN    = idx;
      end
    end
  end

endmodule

// File: rtl/recv_queue_sched.sv
// Receive buffer sequencer: per-queue write addressing, occupancy tracking and
// round-robin DMA burst scheduling with req/gnt handshake.
module recv_queue_sched
  import recv_sched_pkg::*;
#(
  parameter int unsigned NUM_Q     = DEF_NUM_Q,
  parameter int unsigned QN_W      = $clog2(NUM_Q),
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned PTR_W     = $clog2(DEPTH),
  parameter int unsigned BURST_MAX = DEF_BURST_MAX,
  parameter int unsigned AF_MARGIN = DEF_AF_MARGIN,
  parameter int unsigned ADDR_W    = addrWidth(NUM_Q, DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [QN_W-1:0]   QN,
  input  logic              push,
  output logic              ramWrEn,
  output logic [ADDR_W-1:0] ramWrAddr,
  output logic              ramRdEn,
  output logic [ADDR_W-1:0] ramRdAddr,
  input  logic [NUM_Q-1:0]  qEnable,
  output logic [NUM_Q-1:0]  qAlmostFull,
  input  logic              ovfClear,
  output logic              overflow,
  output logic [QN_W-1:0]   overflowQN,
  output logic              dmaReq,
  output logic [QN_W-1:0]   dmaQN,
  output logic [3:0]        dmaLen,
  input  logic              dmaGnt,
  input  logic              dmaDataReady,
  output logic              dmaDataValid,
  output logic              dmaLast
);

  localparam int unsigned        CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   AF_LEVEL  = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0]   BURST_CAP = CNT_W'(BURST_MAX);

  logic [CNT_W-1:0] count     [NUM_Q];
  logic [CNT_W-1:0] nextCount [NUM_Q];
  logic [PTR_W-1:0] wrPtr     [NUM_Q];
  logic [PTR_W-1:0] rdPtr     [NUM_Q];

  schedState_t      state;
  logic [QN_W-1:0]  curQN;
  logic [QN_W-1:0]  rrPtr;
  logic [QN_W-1:0]  arbQN;
  logic [3:0]       burstLen;
  logic [3:0]       remaining;
  logic [3:0]       arbLen;
  logic [NUM_Q-1:0] eligible;
  logic [NUM_Q-1:0] arbGrant;
  logic             rdFire;
  logic             pushAccept;
  logic             pushDrop;

  rr_arbiter #(
    .NUM_Q (NUM_Q),
    .QN_W  (QN_W)
  ) uArb (
    .request (eligible),
    .rrPtr   (rrPtr),
    .grant   (arbGrant),
    .grantQN (arbQN)
  );

  // A full queue still accepts a push when the same cycle drains one word from it.
  always_comb begin
    rdFire     = (state == READ) && dmaDataReady;
    pushAccept = push && ((count[QN] != FULL_CNT) || (rdFire && (curQN == QN)));
    pushDrop   = push && !pushAccept;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      nextCount[q] = count[q];
      if ((pushAccept && (QN == QN_W'(q))) && !(rdFire && (curQN == QN_W'(q)))) begin
        nextCount[q] = count[q] + CNT_W'(1);
      end else if (!(pushAccept && (QN == QN_W'(q))) && (rdFire && (curQN == QN_W'(q)))) begin
        nextCount[q] = count[q] - CNT_W'(1);
      end
      eligible[q] = (count[q] != '0) && qEnable[q];
    end
    arbLen = (count[arbQN] > BURST_CAP) ? 4'(BURST_MAX) : 4'(count[arbQN]);
  end

  assign ramWrEn   = pushAccept;
  assign ramWrAddr = {QN, wrPtr[QN]};
  assign ramRdEn   = rdFire;
  assign ramRdAddr = {curQN, rdPtr[curQN]};
  assign dmaReq    = (state == REQ);
  assign dmaQN     = curQN;
  assign dmaLen    = burstLen;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned q = 0; q < NUM_Q; q++) begin
        count[q] <= '0;
        wrPtr[q] <= '0;
        rdPtr[q] <= '0;
      end
      qAlmostFull <= '0;
    end else begin
      for (int unsigned q = 0; q < NUM_Q; q++) begin
        count[q]       <= nextCount[q];
        qAlmostFull[q] <= (nextCount[q] >= AF_LEVEL);
      end
      if (pushAccept) wrPtr[QN] <= wrPtr[QN] + PTR_W'(1);
      if (rdFire)     rdPtr[curQN] <= rdPtr[curQN] + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      overflowQN <= '0;
    end else if (pushDrop) begin
      overflow <= 1'b1;
      if (!overflow) overflowQN <= QN;
    end else if (ovfClear) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      curQN        <= '0;
      rrPtr        <= '0;
      burstLen     <= '0;
      remaining    <= '0;
      dmaDataValid <= 1'b0;
      dmaLast      <= 1'b0;
    end else begin
      dmaDataValid <= rdFire;
      dmaLast      <= rdFire && (remaining == 4'd1);
      case (state)
        IDLE: begin
          if (|arbGrant) begin
            curQN     <= arbQN;
            burstLen  <= arbLen;
            remaining <= arbLen;
            state     <= REQ;
          end
        end
        REQ: begin
          if (dmaGnt) state <= READ;
        end
        READ: begin
          if (rdFire) begin
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              state <= IDLE;
              rrPtr <= curQN + QN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_queue_sched.sv
// Bench for recv_queue_sched: directed scenarios plus random traffic against a queue-level model.
module tb_recv_queue_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  QN = '0;
  logic        push = 1'b0;
  logic        ramWrEn;
  logic [9:0]  ramWrAddr;
  logic        ramRdEn;
  logic [9:0]  ramRdAddr;
  logic [15:0] qEnable = '0;
  logic [15:0] qAlmostFull;
  logic        ovfClear = 1'b0;
  logic        overflow;
  logic [3:0]  overflowQN;
  logic        dmaReq;
  logic [3:0]  dmaQN;
  logic [3:0]  dmaLen;
  logic        dmaGnt = 1'b0;
  logic        dmaDataReady = 1'b0;
  logic        dmaDataValid;
  logic        dmaLast;

  always #5 clock = ~clock;

  recv_queue_sched dut (
    .clock        (clock),
    .reset        (reset),
    .QN           (QN),
    .push         (push),
    .ramWrEn      (ramWrEn),
    .ramWrAddr    (ramWrAddr),
    .ramRdEn      (ramRdEn),
    .ramRdAddr    (ramRdAddr),
    .qEnable      (qEnable),
    .qAlmostFull  (qAlmostFull),
    .ovfClear     (ovfClear),
    .overflow     (overflow),
    .overflowQN   (overflowQN),
    .dmaReq       (dmaReq),
    .dmaQN        (dmaQN),
    .dmaLen       (dmaLen),
    .dmaGnt       (dmaGnt),
    .dmaDataReady (dmaDataReady),
    .dmaDataValid (dmaDataValid),
    .dmaLast      (dmaLast)
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue-level model: occupancy and pointers per queue, plus the burst in flight.
  int   mCnt [16];
  int   mWp  [16];
  int   mRp  [16];
  bit   mAf  [16];
  bit   mOvf;
  int   mOvfQ;
  int   mRr;
  bit   mWaitGnt, mReading;
  int   mCur, mLen, mRem;
  bit   mValid, mLast;
  bit   mRd, mAcc;
  logic [15:0] mAfVec;

  function automatic void modelReset();
    for (int q = 0; q < 16; q++) begin
      mCnt[q] = 0; mWp[q] = 0; mRp[q] = 0; mAf[q] = 0;
    end
    mOvf = 0; mOvfQ = 0; mRr = 0; mWaitGnt = 0; mReading = 0;
    mCur = 0; mLen = 0; mRem = 0; mValid = 0; mLast = 0;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      modelReset();
      chk("rstWrEn",   32'(ramWrEn),      32'd0);
      chk("rstWrAddr", 32'(ramWrAddr),    32'd0);
      chk("rstRdEn",   32'(ramRdEn),      32'd0);
      chk("rstRdAddr", 32'(ramRdAddr),    32'd0);
      chk("rstReq",    32'(dmaReq),       32'd0);
      chk("rstQN",     32'(dmaQN),        32'd0);
      chk("rstLen",    32'(dmaLen),       32'd0);
      chk("rstValid",  32'(dmaDataValid), 32'd0);
      chk("rstLast",   32'(dmaLast),      32'd0);
      chk("rstAf",     32'(qAlmostFull),  32'd0);
      chk("rstOvf",    32'(overflow),     32'd0);
      chk("rstOvfQN",  32'(overflowQN),   32'd0);
    end else begin
      mRd  = mReading && dmaDataReady;
      mAcc = push && ((mCnt[QN] != 64) || (mRd && (mCur == int'(QN))));
      for (int q = 0; q < 16; q++) mAfVec[q] = mAf[q];

      chk("wrEn", 32'(ramWrEn), 32'(mAcc));
      if (push) chk("wrAddr", 32'(ramWrAddr), 32'(int'(QN) * 64 + mWp[QN]));
      chk("rdEn", 32'(ramRdEn), 32'(mRd));
      if (mRd) chk("rdAddr", 32'(ramRdAddr), 32'(mCur * 64 + mRp[mCur]));
      chk("dmaReq", 32'(dmaReq), 32'(mWaitGnt));
      if (mWaitGnt || mReading) begin
        chk("dmaQN",  32'(dmaQN),  32'(mCur));
        chk("dmaLen", 32'(dmaLen), 32'(mLen));
      end
      chk("dmaValid",    32'(dmaDataValid), 32'(mValid));
      chk("dmaLast",     32'(dmaLast),      32'(mLast));
      chk("qAlmostFull", 32'(qAlmostFull),  32'(mAfVec));
      chk("overflow",    32'(overflow),     32'(mOvf));
      chk("overflowQN",  32'(overflowQN),   32'(mOvfQ));

      mValid = mRd;
      mLast  = mRd && (mRem == 1);
      if (!mWaitGnt && !mReading) begin
        for (int i = 0; i < 16; i++) begin
          int q;
          q = (mRr + i) % 16;
          if (mCnt[q] > 0 && qEnable[q]) begin
            mCur = q;
            mLen = (mCnt[q] > 8) ? 8 : mCnt[q];
            mRem = mLen;
            mWaitGnt = 1;
            break;
          end
        end
      end else if (mWaitGnt) begin
        if (dmaGnt) begin
          mWaitGnt = 0;
          mReading = 1;
        end
      end else if (mRd) begin
        mRp[mCur] = (mRp[mCur] + 1) % 64;
        mCnt[mCur]--;
        mRem--;
        if (mRem == 0) begin
          mReading = 0;
          mRr = (mCur + 1) % 16;
        end
      end
      if (mAcc) begin
        mCnt[QN]++;
        mWp[QN] = (mWp[QN] + 1) % 64;
      end
      if (push && !mAcc) begin
        if (!mOvf) mOvfQ = int'(QN);
        mOvf = 1;
      end else if (ovfClear) begin
        mOvf = 0;
      end
      for (int q = 0; q < 16; q++) mAf[q] = (mCnt[q] >= 56);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic waitReq(input string name);
    int k;
    k = 0;
    while (!dmaReq && k < 40) begin
      step();
      k++;
    end
    chk(name, 32'(dmaReq), 32'd1);
  endtask

  task automatic collectOrder(input int n, output int order [3]);
    int got, k;
    got = 0; k = 0;
    for (int i = 0; i < 3; i++) order[i] = -1;
    while (got < n && k < 200) begin
      if (dmaReq) begin
        order[got] = int'(dmaQN);
        got++;
      end
      step();
      k++;
    end
  endtask

  initial begin
    int valids, lastIdx, k;
    bit found;
    int order [3];

    repeat (3) step();
    reset = 1'b1;
    step();

    // Scenario: three words into queue 5, then one burst of 3.
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; QN = 4'd5;
      #2;
      chk("t1WrEn",   32'(ramWrEn),   32'd1);
      chk("t1WrAddr", 32'(ramWrAddr), 32'h140 + 32'(i));
      step();
    end
    push = 1'b0;
    qEnable = 16'h0020; dmaGnt = 1'b1; dmaDataReady = 1'b1;
    waitReq("t1Req");
    chk("t1Len", 32'(dmaLen), 32'd3);
    chk("t1QN",  32'(dmaQN),  32'd5);
    valids = 0; lastIdx = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dmaDataValid) valids++;
      if (dmaLast) lastIdx = valids;
    end
    chk("t1Valids",  32'(valids),  32'd3);
    chk("t1LastIdx", 32'(lastIdx), 32'd3);
    chk("t1Drained", 32'(dmaReq),  32'd0);
    qEnable = '0;

    // Scenario: fill queue 2 past full.
    for (int i = 0; i < 65; i++) begin
      push = 1'b1; QN = 4'd2;
      #2;
      if (i == 64) chk("t2DropWrEn", 32'(ramWrEn), 32'd0);
      if (i == 55) chk("t2AfBefore", 32'(qAlmostFull[2]), 32'd0);
      step();
      if (i == 55) chk("t2AfAt56", 32'(qAlmostFull[2]), 32'd1);
    end
    push = 1'b0;
    chk("t2Ovf",   32'(overflow),   32'd1);
    chk("t2OvfQN", 32'(overflowQN), 32'd2);
    ovfClear = 1'b1;
    step();
    ovfClear = 1'b0;
    chk("t2Clear", 32'(overflow), 32'd0);

    // Scenario: push into full queue 2 while it is being read.
    qEnable = 16'h0004; dmaGnt = 1'b1; dmaDataReady = 1'b1;
    found = 0; k = 0;
    while (!found && k < 30) begin
      #2;
      if (ramRdEn) begin
        push = 1'b1; QN = 4'd2;
        #1;
        chk("t5WrEn", 32'(ramWrEn), 32'd1);
        found = 1;
      end
      step();
      push = 1'b0;
      k++;
    end
    chk("t5Found", 32'(found),    32'd1);
    chk("t5NoOvf", 32'(overflow), 32'd0);
    repeat (150) step();
    qEnable = '0;

    // Scenario: held grant, stalling ready, then reset mid-burst.
    dmaGnt = 1'b0; dmaDataReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; QN = 4'd7;
      step();
    end
    push = 1'b0;
    qEnable = 16'h0080;
    waitReq("t6Req");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6ReqHeld", 32'(dmaReq), 32'd1);
    end
    dmaGnt = 1'b1;
    step();
    dmaDataReady = 1'b1; step();
    dmaDataReady = 1'b0; step();
    dmaDataReady = 1'b1; step();
    QN = '0; push = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6RstReq",   32'(dmaReq),       32'd0);
    chk("t6RstRdEn",  32'(ramRdEn),      32'd0);
    chk("t6RstValid", 32'(dmaDataValid), 32'd0);
    step(); step();
    reset = 1'b1;
    dmaDataReady = 1'b0;
    repeat (4) step();
    chk("t6Clean", 32'(dmaReq), 32'd0);

    // Scenario: round-robin order across queues 1, 4, 9 and after refill.
    qEnable = '0; dmaDataReady = 1'b1;
    foreach (order[i]) order[i] = 0;
    for (int i = 0; i < 6; i++) begin
      push = 1'b1;
      QN = (i < 2) ? 4'd1 : ((i < 4) ? 4'd4 : 4'd9);
      step();
    end
    push = 1'b0;
    qEnable = 16'h0212;
    collectOrder(3, order);
    chk("t3First",  32'(order[0]), 32'd1);
    chk("t3Second", 32'(order[1]), 32'd4);
    chk("t3Third",  32'(order[2]), 32'd9);
    repeat (10) step();
    qEnable = '0;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      QN = (i < 2) ? 4'd4 : 4'd1;
      step();
    end
    push = 1'b0;
    qEnable = 16'h0012;
    collectOrder(2, order);
    chk("t3Refill1", 32'(order[0]), 32'd1);
    chk("t3Refill2", 32'(order[1]), 32'd4);
    repeat (10) step();

    // Random traffic; queue 3 is favoured so it saturates and overflows.
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        push = 1'b0; QN = '0; ovfClear = 1'b0;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
      end
      push = ($urandom_range(2, 0) != 0);
      QN = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'd3;
      if (c % 50 == 0) qEnable = 16'($urandom_range(65535, 0));
      dmaGnt = 1'($urandom_range(1, 0));
      dmaDataReady = ($urandom_range(3, 0) != 0);
      ovfClear = ($urandom_range(63, 0) == 0);
      step();
    end
    push = 1'b0; ovfClear = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
